// File: rtl/multi_ro_arbiter.sv
// multi_ro_arbiter
// Round-robin readout scheduler: grants one channel FIFO at a time and
// copies a bounded burst into the shared output FIFO as header, data words
// and trailer. OUT_FULL is expected to be the output FIFO's almost-full flag
// (one slot of slack) because the write strobe is registered.

module multi_ro_arbiter #(
    parameter int NCH       = 4,
    parameter int DW        = 16,
    parameter int MAX_BURST = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [NCH-1:0]    DAVAIL,
    input  logic [NCH*DW-1:0] CH_DATA,
    output logic [NCH-1:0]    CH_RDEN,
    input  logic              OUT_FULL,
    output logic              OUT_WR_EN,
    output logic [DW-1:0]     OUT_DATA,
    output logic [1:0]        OUT_TAG,
    output logic [3:0]        CH_SEL,
    output logic              BUSY
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARB,
        S_HEADER,
        S_READ,
        S_TRAILER
    } state_t;

    localparam logic [1:0] TAG_HDR    = 2'b01;
    localparam logic [1:0] TAG_DATA   = 2'b00;
    localparam logic [1:0] TAG_TRL    = 2'b10;
    localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);
    localparam logic [3:0] PTR_RESET  = 4'(NCH - 1);

    state_t          r_state;
    logic [3:0]      r_ptr;       // last served channel
    logic [3:0]      r_ch_sel;    // channel granted for the current frame
    logic [7:0]      r_count;     // data words popped in the current frame
    logic            r_wr_en;
    logic [DW-1:0]   r_data;
    logic [1:0]      r_tag;

    logic            w_sel_davail;
    logic [DW-1:0]   w_sel_data;
    logic            w_found;
    logic [3:0]      w_grant;
    logic            w_pop;

    // Select the granted channel's data-available flag and head word.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        w_sel_davail = 1'b0;
        w_sel_data   = '0;
        for (int i = 0; i < NCH; i++) begin
            if (r_ch_sel == 4'(i)) begin
                w_sel_davail = DAVAIL[i];
                w_sel_data   = CH_DATA[i*DW +: DW];
            end
        end
    end

    // Round-robin scan: first requesting channel after the last served one, wrapping.
    always_comb begin
        w_found = 1'b0;
        w_grant = r_ptr;
        for (int k = 1; k <= NCH; k++) begin
            for (int j = 0; j < NCH; j++) begin
                if (!w_found && DAVAIL[j] && ((int'(r_ptr) + k) % NCH) == j) begin
                    w_found = 1'b1;
                    w_grant = 4'(j);
                end
            end
        end
    end

    // A pop happens only in READ with data present and room downstream; a
    // pending reset suppresses it so no word is consumed and then dropped.
    assign w_pop = (r_state == S_READ) && w_sel_davail && !OUT_FULL && !RST;

    // Drive the pop strobe of the granted channel only.
    always_comb begin
        CH_RDEN = '0;
        for (int i = 0; i < NCH; i++) begin
            CH_RDEN[i] = w_pop && (r_ch_sel == 4'(i));
        end
    end

    // Frame sequencer with registered write port.
    always_ff @(posedge CLK) begin
        if (RST) begin
            // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
            r_state  <= S_IDLE;
            r_ptr    <= PTR_RESET;
            r_ch_sel <= '0;
            r_count  <= '0;
            r_wr_en  <= 1'b0;
            r_data   <= '0;
            r_tag    <= '0;
        end else begin
            r_wr_en <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (|DAVAIL) r_state <= S_ARB;
                end
                S_ARB: begin
                    if (w_found) begin
                        r_ch_sel <= w_grant;
                        r_ptr    <= w_grant;
                        r_state  <= S_HEADER;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_HEADER: begin
                    if (!OUT_FULL) begin
                        r_wr_en <= 1'b1;
                        r_data  <= DW'(r_ch_sel);
                        r_tag   <= TAG_HDR;
                        r_state <= S_READ;
                    end
                end
                S_READ: begin
                    if (w_pop) begin
                        r_wr_en <= 1'b1;
                        r_data  <= w_sel_data;
                        r_tag   <= TAG_DATA;
                        r_count <= r_count + 8'd1;
                        if (r_count == BURST_LAST) r_state <= S_TRAILER;
                    end else if (!w_sel_davail) begin
                        r_state <= S_TRAILER;
                    end
                end
                S_TRAILER: begin
                    if (!OUT_FULL) begin
                        r_wr_en <= 1'b1;
                        r_data  <= DW'(r_count);
                        r_tag   <= TAG_TRL;
                        r_count <= '0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign OUT_WR_EN = r_wr_en;
    assign OUT_DATA  = r_data;
    assign OUT_TAG   = r_tag;
    assign CH_SEL    = r_ch_sel;
    assign BUSY      = (r_state != S_IDLE);

endmodule
